fetch_unit: RTL

Instruction fetch and next-PC stage of the MIPS core; sits directly upstream of main_decoder/alu_decoder.
- Holds the PC and fetches words from instruction memory over a ready handshake.
- Presents one instruction at a time to decode and waits for decode/execute to accept it.
- Computes the next PC from the control signals the decoders and ALU return for that instruction: jump, 2-bit branch (2'b10 beq, 2'b11 bne) and ALU zero.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/next_pc_logic.sv | 26 ++
 rtl/fetch_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, branch encodings, fetch FSM states and reset PC.
// Used by fetch_unit, next_pc_logic and the single-cycle datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b10;
    localparam logic [1:0] BR_NE   = 2'b11;

    // Fetch FSM encoding kept as plain constants so legacy tools can consume it.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_ISSUE = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic branch_taken(input logic [1:0] branch, input logic zero);
        return branch[1] & (zero ^ branch[0]);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// master = fetch_unit, slave = memory/decoder side.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [1:0]  branch;
    logic        jump;
    logic        zero;
    logic [31:0] imm_ext;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        input  imem_rdata, imem_ready, instr_ready, branch, jump, zero, imm_ext
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        output imem_rdata, imem_ready, instr_ready, branch, jump, zero, imm_ext
    );

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// Shared with the single-cycle datapath.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic [31:0] imm_ext,
    input  logic [1:0]  branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pcplus4,
    output logic [31:0] next_pc
);

    always_comb begin
        pcplus4 = pc + 32'd4;
        next_pc = pcplus4;
        if (jump) begin
            next_pc = {pcplus4[31:28], instr, 2'b00};
        end else if (branch_taken(branch, zero)) begin
            next_pc = pcplus4 + {imm_ext[29:0], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: IDLE -> FETCH -> ISSUE loop over a ready handshake.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_unit_if.master     bus,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcplus4;
    logic [31:0]  next_pc;
    logic         accept;

    assign accept = (state == ST_ISSUE) && bus.instr_ready;

    next_pc_logic u_next_pc (
        .pc      (pc_q),
        .instr   (instr_q[25:0]),
        .imm_ext (bus.imm_ext),
        .branch  (bus.branch),
        .jump    (bus.jump),
        .zero    (bus.zero),
        .pcplus4 (pcplus4),
        .next_pc (next_pc)
    );

    // Memory data is only captured in FETCH and pc only moves on an accepted issue,
    // so stray handshakes in other states are ignored by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        instr_q <= bus.imem_rdata;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) begin
                        pc_q  <= next_pc;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == ST_ISSUE);
    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pcplus4;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] redirect_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q  <= '0;
            redirect_q <= '0;
        end else if (accept) begin
            retired_q <= retired_q + CNT_W'(1);
            if (bus.jump || branch_taken(bus.branch, bus.zero)) begin
                redirect_q <= redirect_q + CNT_W'(1);
            end
        end
    end

    assign retired_cnt  = retired_q;
    assign redirect_cnt = redirect_q;
`else
    assign retired_cnt  = '0;
    assign redirect_cnt = '0;
`endif

endmodule
